// File: rtl/keypad_event_buffer.sv
// Keypad scanner consumer: 2-flop sync, press/release debounce FSM, one code per
// accepted press queued in a show-ahead circular FIFO with sticky overflow.
module keypad_event_buffer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DEPTH           = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         key_int,
  input  logic [3:0]                   key_data,
  input  logic                         pop,
  output logic [3:0]                   data_out,
  output logic                         data_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH+1);

  typedef enum logic [1:0] {S_IDLE, S_PRESS_DB, S_HELD, S_REL_DB} state_t;

  logic             r_int_s1, r_int_s2;
  logic [3:0]       r_data_s1, r_data_s2;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]       r_cap, w_cap_nxt;
  logic             w_push, w_cnt_done;

  logic [3:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             w_do_pop, w_do_push;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_int_s1  <= 1'b0;
      r_int_s2  <= 1'b0;
      r_data_s1 <= 4'h0;
      r_data_s2 <= 4'h0;
    end else begin
      r_int_s1  <= key_int;
      r_int_s2  <= r_int_s1;
      r_data_s1 <= key_data;
      r_data_s2 <= r_data_s1;
    end
  end

  assign w_cnt_done = (r_cnt == CNT_W'(DEBOUNCE_CYCLES-1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cap   <= 4'h0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cap   <= w_cap_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cap_nxt   = r_cap;
    case (r_state)
      S_IDLE: if (r_int_s2) begin
        w_state_nxt = S_PRESS_DB;
        w_cap_nxt   = r_data_s2;
        w_cnt_nxt   = '0;
      end
      S_PRESS_DB: begin
        // Any drop or code change while debouncing restarts from idle.
        if (!r_int_s2 || r_data_s2 != r_cap) w_state_nxt = S_IDLE;
        else if (w_cnt_done)                 w_state_nxt = S_HELD;
        else                                 w_cnt_nxt   = r_cnt + 1'b1;
      end
      S_HELD: if (!r_int_s2) begin
        w_state_nxt = S_REL_DB;
        w_cnt_nxt   = '0;
      end
      S_REL_DB: begin
        if (r_int_s2) begin
          w_state_nxt = S_HELD;
          w_cnt_nxt   = '0;
        end else if (w_cnt_done) w_state_nxt = S_IDLE;
        else                     w_cnt_nxt   = r_cnt + 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_push = 1'b0;
    if (r_state == S_PRESS_DB && r_int_s2 && r_data_s2 == r_cap && w_cnt_done)
      w_push = 1'b1;
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_do_pop  = pop && (r_count != '0);
  assign w_do_push = w_push && ((r_count != CW'(DEPTH)) || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= r_cap;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
      if (w_push && !w_do_push) r_overflow <= 1'b1;
    end
  end

  assign data_out   = (r_count != '0) ? r_mem[r_rd_ptr] : 4'h0;
  assign data_valid = (r_count != '0);
  assign count      = r_count;
  assign overflow   = r_overflow;
endmodule

// File: tb/tb_keypad_event_buffer.sv
// Scoreboard bench for keypad_event_buffer: expected codes queued on accepted presses,
// compared as the FIFO is popped.
module tb_keypad_event_buffer;
  logic       clk = 1'b0;
  logic       reset, key_int, pop;
  logic [3:0] key_data;
  wire  [3:0] data_out;
  wire        data_valid;
  wire  [2:0] count;
  wire        overflow;

  keypad_event_buffer #(.DEBOUNCE_CYCLES(4), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .key_int(key_int), .key_data(key_data), .pop(pop),
    .data_out(data_out), .data_valid(data_valid), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int         checks = 0, errors = 0;
  logic [3:0] sb[$];
  logic       exp_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic expect_push(input logic [3:0] c);
    if (sb.size() < 4) sb.push_back(c);
    else exp_ovf = 1'b1;
  endtask

  task automatic press(input logic [3:0] c, input int hold);
    key_data = c; key_int = 1'b1;
    tick(hold);
    key_int = 1'b0; key_data = 4'h0;
    expect_push(c);
    tick(10);
    chk("press_count", 32'(count), 32'(sb.size()));
    chk("press_ovf", 32'(overflow), 32'(exp_ovf));
  endtask

  task automatic pop_one();
    logic [3:0] e;
    e = sb.pop_front();
    chk("pop_valid", 32'(data_valid), 32'd1);
    chk("pop_data", 32'(data_out), 32'(e));
    pop = 1'b1; tick(); pop = 1'b0;
  endtask

  task automatic drain();
    while (sb.size() != 0) pop_one();
    chk("drain_valid", 32'(data_valid), 32'd0);
    chk("drain_data", 32'(data_out), 32'd0);
    chk("drain_count", 32'(count), 32'd0);
  endtask

  initial begin
    logic [7:0] pat;
    reset = 1'b0; key_int = 1'b0; key_data = 4'h0; pop = 1'b0;
    tick(2);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b1; tick(2);

    // Clean press of 9: visible exactly after the 7th sampling edge.
    key_data = 4'h9; key_int = 1'b1;
    tick(6);
    chk("lat_early_valid", 32'(data_valid), 32'd0);
    tick(1);
    chk("lat_valid", 32'(data_valid), 32'd1);
    chk("lat_data", 32'(data_out), 32'h9);
    chk("lat_count", 32'(count), 32'd1);
    tick(13);
    key_int = 1'b0; tick(10);
    sb.push_back(4'h9);
    chk("clean_single_push", 32'(count), 32'd1);
    drain();

    // Bounce: short blip rejected, one push after the final stable run.
    pat = 8'b1111_1011;
    key_data = 4'h3;
    for (int i = 0; i < 8; i++) begin key_int = pat[i]; tick(); end
    tick(5);
    key_int = 1'b0; tick(10);
    sb.push_back(4'h3);
    chk("bounce_count", 32'(count), 32'd1);
    drain();

    // Release chatter: a 2-cycle drop and a code change while held must not push.
    key_data = 4'hD; key_int = 1'b1; tick(12);
    key_int = 1'b0; tick(2);
    key_int = 1'b1; key_data = 4'hE; tick(10);
    key_int = 1'b0; tick(10);
    sb.push_back(4'hD);
    chk("chatter_count", 32'(count), 32'd1);
    press(4'h5, 8);
    drain();

    // Five presses into a depth-4 FIFO.
    for (int i = 1; i <= 5; i++) press(4'(i), 8);
    chk("full_count", 32'(count), 32'd4);
    chk("full_ovf", 32'(overflow), 32'd1);
    drain();

    reset = 1'b0; tick(); reset = 1'b1; exp_ovf = 1'b0;
    chk("rst2_ovf", 32'(overflow), 32'd0);
    tick(2);

    // Full FIFO with a pop landing on the push edge of A.
    press(4'h6, 8); press(4'h7, 8); press(4'h8, 8); press(4'hB, 8);
    key_data = 4'hA; key_int = 1'b1;
    tick(6);
    chk("pp_pre_count", 32'(count), 32'd4);
    chk("pp_pre_data", 32'(data_out), 32'(sb[0]));
    pop = 1'b1; tick(); pop = 1'b0;
    void'(sb.pop_front());
    sb.push_back(4'hA);
    chk("pp_count", 32'(count), 32'd4);
    chk("pp_ovf", 32'(overflow), 32'd0);
    key_int = 1'b0; tick(10);
    chk("pp_post_count", 32'(count), 32'd4);
    chk("pp_post_ovf", 32'(overflow), 32'd0);
    drain();

    // Async reset mid-debounce with two entries queued.
    press(4'h1, 8); press(4'h2, 8);
    key_data = 4'h5; key_int = 1'b1;
    tick(4);
    reset = 1'b0; #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_valid", 32'(data_valid), 32'd0);
    chk("arst_data", 32'(data_out), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    sb.delete();
    key_int = 1'b0; key_data = 4'h0;
    tick(2);
    reset = 1'b1; tick(10);
    chk("arst_post_count", 32'(count), 32'd0);
    press(4'hC, 8);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
